xmem_arbiter: RTL and testbench

XMEM_ARBITER -- requirements
Module: xmem_arbiter

---
 rtl/xmem_pkg.sv | 38 +++
 rtl/xmem_arbiter.sv | 186 ++++++++++++++++++
 tb/tb_xmem_arbiter.sv | 393 +++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/xmem_pkg.sv
// xmem_pkg
// Shared definitions for the external-memory arbiter: the FSM state
// encoding, the data pattern returned to a master whose transfer was
// forcibly terminated, the stall-counter width and the round-robin tie-break.
// No ports (package).

package xmem_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_BUSY    = 2'd1,
    ST_TOFLUSH = 2'd2
  } xmem_state_t;

  localparam int STALL_CNT_W = 16;

  // Read data handed back on a forced termination so software sees an
  // obviously bogus value.
  localparam logic [0:31] XMEM_FILL_ONES = 32'hFFFF_FFFF;

  // Winner selection out of IDLE.
  // - Both masters requesting: the one that did not own the bus last wins.
  // - Only one master requesting: that master wins.
  // - Neither requesting: result is don't-care (0); the caller doesn't grant.
  function automatic logic rr_pick(input logic cyc0, input logic cyc1,
                                   input logic last_owner);
    logic pick;
    if (cyc0 && cyc1) begin
      pick = ~last_owner;
    end else if (cyc1) begin
      pick = 1'b1;
    end else begin
      pick = 1'b0;
    end
    return pick;
  endfunction

endpackage

// File: rtl/xmem_arbiter.sv
// xmem_arbiter
// Two-master, one-slave Wishbone-style arbiter in front of external memory.
// Master 0 is the service processor, master 1 the DMA/secondary master.
// The grant is locked for as long as the owner holds cyc, so multi-beat
// bursts are never split. A stalled slave is cut off after TIMEOUT_CYCLES
// un-acked strobe cycles: the owner gets a single ack carrying all-ones data,
// and a sticky flag records that this happened.
//
// Ports
//   clk, reset        : clock, synchronous active-high reset
//   m0_* / m1_*       : master request (adr, dat, we, sel, stb, cyc) and
//                       response (dat_o, ack_o)
//   s_*_o / s_dat_i,
//   s_ack_i           : slave request / response
//   owner             : grant holder, meaningful only while busy
//   busy              : a master holds the grant (BUSY or TOFLUSH)
//   timeout_flag      : sticky forced-termination indicator, cleared by reset
//
// TIMEOUT_CYCLES must lie in 2..65535 to fit the 16-bit stall counter.

module xmem_arbiter
  import xmem_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic        clk,
  input  logic        reset,

  input  logic [2:31] m0_adr_i,
  input  logic [0:31] m0_dat_i,
  input  logic        m0_we_i,
  input  logic [0:3]  m0_sel_i,
  input  logic        m0_stb_i,
  input  logic        m0_cyc_i,
  output logic [0:31] m0_dat_o,
  output logic        m0_ack_o,

  input  logic [2:31] m1_adr_i,
  input  logic [0:31] m1_dat_i,
  input  logic        m1_we_i,
  input  logic [0:3]  m1_sel_i,
  input  logic        m1_stb_i,
  input  logic        m1_cyc_i,
  output logic [0:31] m1_dat_o,
  output logic        m1_ack_o,

  output logic [2:31] s_adr_o,
  output logic [0:31] s_dat_o,
  output logic        s_we_o,
  output logic [0:3]  s_sel_o,
  output logic        s_stb_o,
  output logic        s_cyc_o,
  input  logic [0:31] s_dat_i,
  input  logic        s_ack_i,

  output logic        owner,
  output logic        busy,
  output logic        timeout_flag
);

  localparam logic [STALL_CNT_W-1:0] STALL_LIMIT = STALL_CNT_W'(TIMEOUT_CYCLES - 1);

  xmem_state_t             state;
  logic                    owner_q;
  logic                    last_owner_q;
  logic [STALL_CNT_W-1:0]  stall_cnt;
  logic                    timeout_q;

  logic                    own_cyc;
  logic                    own_stb;

  // Owner's cyc/stb, used by the FSM to detect release and stalls.
  always_comb begin
    own_cyc = owner_q ? m1_cyc_i : m0_cyc_i;
    own_stb = owner_q ? m1_stb_i : m0_stb_i;
  end

  // Arbitration FSM.
  // Release (owner cyc low) is tested before the stall logic, so an aborted
  // strobe just ends the grant and no ack is produced. An ack in the same
  // cycle the counter hits its limit clears the counter, so the ack wins.
  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= ST_IDLE;
      owner_q      <= 1'b0;
      last_owner_q <= 1'b1;
      stall_cnt    <= '0;
      timeout_q    <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          stall_cnt <= '0;
          if (m0_cyc_i || m1_cyc_i) begin
            owner_q <= rr_pick(m0_cyc_i, m1_cyc_i, last_owner_q);
            state   <= ST_BUSY;
          end
        end

        ST_BUSY: begin
          if (!own_cyc) begin
            state        <= ST_IDLE;
            last_owner_q <= owner_q;
            stall_cnt    <= '0;
          end else if (s_ack_i || !own_stb) begin
            stall_cnt <= '0;
          end else if (stall_cnt == STALL_LIMIT) begin
            state     <= ST_TOFLUSH;
            timeout_q <= 1'b1;
            stall_cnt <= '0;
          end else begin
            stall_cnt <= stall_cnt + 1'b1;
          end
        end

        ST_TOFLUSH: begin
          state        <= ST_IDLE;
          last_owner_q <= owner_q;
          stall_cnt    <= '0;
        end

        default: begin
          state     <= ST_IDLE;
          stall_cnt <= '0;
        end
      endcase
    end
  end

  // Request/response steering. Everything defaults to zero, so IDLE exposes
  // no request to the slave and a slave ack outside BUSY goes nowhere.
  always_comb begin
    s_adr_o  = '0;
    s_dat_o  = '0;
    s_we_o   = 1'b0;
    s_sel_o  = '0;
    s_stb_o  = 1'b0;
    s_cyc_o  = 1'b0;
    m0_dat_o = '0;
    m0_ack_o = 1'b0;
    m1_dat_o = '0;
    m1_ack_o = 1'b0;

    case (state)
      ST_BUSY: begin
        if (owner_q) begin
          s_adr_o  = m1_adr_i;
          s_dat_o  = m1_dat_i;
          s_we_o   = m1_we_i;
          s_sel_o  = m1_sel_i;
          s_stb_o  = m1_stb_i;
          s_cyc_o  = m1_cyc_i;
          m1_dat_o = s_dat_i;
          m1_ack_o = s_ack_i;
        end else begin
          s_adr_o  = m0_adr_i;
          s_dat_o  = m0_dat_i;
          s_we_o   = m0_we_i;
          s_sel_o  = m0_sel_i;
          s_stb_o  = m0_stb_i;
          s_cyc_o  = m0_cyc_i;
          m0_dat_o = s_dat_i;
          m0_ack_o = s_ack_i;
        end
      end

      // Slave is already disconnected; the owner gets its terminating ack.
      ST_TOFLUSH: begin
        if (owner_q) begin
          m1_dat_o = XMEM_FILL_ONES;
          m1_ack_o = 1'b1;
        end else begin
          m0_dat_o = XMEM_FILL_ONES;
          m0_ack_o = 1'b1;
        end
      end

      default: begin
      end
    endcase
  end

  assign busy         = (state != ST_IDLE);
  assign owner        = owner_q;
  assign timeout_flag = timeout_q;

endmodule

// File: tb/tb_xmem_arbiter.sv
// tb_xmem_arbiter
// Self-checking bench for xmem_arbiter (TIMEOUT_CYCLES = 8). A behavioural
// model tracks who holds the bus, how long the slave has stalled and whether
// a forced termination is under way. Every negedge the DUT outputs are
// compared against what that model says they must be. Directed sequences with
// literal expectations pin the model, then randomized traffic follows.

module tb_xmem_arbiter;

  localparam int TIMEOUT = 8;

  logic        clk;
  logic        rst;

  logic [2:31] m_adr [2];
  logic [0:31] m_dat [2];
  logic        m_we  [2];
  logic [0:3]  m_sel [2];
  logic        m_stb [2];
  logic        m_cyc [2];

  logic [0:31] m0_dat_o, m1_dat_o;
  logic        m0_ack_o, m1_ack_o;

  logic [2:31] s_adr_o;
  logic [0:31] s_dat_o;
  logic        s_we_o;
  logic [0:3]  s_sel_o;
  logic        s_stb_o, s_cyc_o;
  logic [0:31] s_dat;
  logic        s_ack;

  logic        owner, busy, timeout_flag;

  int errors = 0;
  int checks = 0;

  // Model state: holder = -1 means nobody owns the bus.
  int mdl_holder;
  int mdl_last;
  int mdl_stall;
  bit mdl_flush;
  bit mdl_tflag;
  bit mdl_valid = 0;

  xmem_arbiter #(.TIMEOUT_CYCLES(TIMEOUT)) dut (
    .clk          (clk),
    .reset        (rst),
    .m0_adr_i     (m_adr[0]),
    .m0_dat_i     (m_dat[0]),
    .m0_we_i      (m_we[0]),
    .m0_sel_i     (m_sel[0]),
    .m0_stb_i     (m_stb[0]),
    .m0_cyc_i     (m_cyc[0]),
    .m0_dat_o     (m0_dat_o),
    .m0_ack_o     (m0_ack_o),
    .m1_adr_i     (m_adr[1]),
    .m1_dat_i     (m_dat[1]),
    .m1_we_i      (m_we[1]),
    .m1_sel_i     (m_sel[1]),
    .m1_stb_i     (m_stb[1]),
    .m1_cyc_i     (m_cyc[1]),
    .m1_dat_o     (m1_dat_o),
    .m1_ack_o     (m1_ack_o),
    .s_adr_o      (s_adr_o),
    .s_dat_o      (s_dat_o),
    .s_we_o       (s_we_o),
    .s_sel_o      (s_sel_o),
    .s_stb_o      (s_stb_o),
    .s_cyc_o      (s_cyc_o),
    .s_dat_i      (s_dat),
    .s_ack_i      (s_ack),
    .owner        (owner),
    .busy         (busy),
    .timeout_flag (timeout_flag)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h (t=%0t)", name, actual, expected, $time);
    end
  endtask

  // Advance to just after the next rising edge; inputs are driven here.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Let combinational outputs settle before a literal check.
  task automatic probe();
    #2;
  endtask

  task automatic idleInputs();
    for (int i = 0; i < 2; i++) begin
      m_cyc[i] = 1'b0;
      m_stb[i] = 1'b0;
      m_we[i]  = 1'b0;
      m_sel[i] = 4'h0;
      m_adr[i] = '0;
      m_dat[i] = '0;
    end
    s_ack = 1'b0;
    s_dat = '0;
  endtask

  task automatic applyReset();
    rst = 1'b1;
    idleInputs();
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic request(input int m, input logic [2:31] adr);
    m_cyc[m] = 1'b1;
    m_stb[m] = 1'b1;
    m_adr[m] = adr;
    m_we[m]  = 1'b0;
    m_sel[m] = 4'hF;
    m_dat[m] = 32'($urandom);
  endtask

  task automatic release_m(input int m);
    m_cyc[m] = 1'b0;
    m_stb[m] = 1'b0;
  endtask

  // One cycle of random traffic. mode 1 makes masters sticky and the slave
  // nearly silent so that stall timeouts actually occur.
  task automatic applyStimulus(input int mode);
    for (int i = 0; i < 2; i++) begin
      if (!m_cyc[i]) begin
        if ($urandom_range(99) < 30) begin
          m_cyc[i] = 1'b1;
          m_stb[i] = 1'b1;
          m_adr[i] = 30'($urandom);
          m_we[i]  = 1'($urandom);
          m_sel[i] = 4'($urandom);
        end else begin
          m_stb[i] = 1'b0;
        end
      end else if ($urandom_range(99) < (mode != 0 ? 3 : 15)) begin
        m_cyc[i] = 1'b0;
        m_stb[i] = 1'($urandom);
      end else begin
        m_stb[i] = ($urandom_range(99) < (mode != 0 ? 97 : 75));
        m_adr[i] = 30'($urandom);
      end
      m_dat[i] = 32'($urandom);
    end
    s_ack = ($urandom_range(99) < (mode != 0 ? 2 : 40));
    s_dat = 32'($urandom);
    rst   = ($urandom_range(999) < 3);
  endtask

  // Reference model, advanced on every rising edge from the inputs present
  // at that edge.
  task automatic updateModel();
    if (rst) begin
      mdl_holder = -1;
      mdl_last   = 1;
      mdl_stall  = 0;
      mdl_flush  = 1'b0;
      mdl_tflag  = 1'b0;
      mdl_valid  = 1'b1;
    end else if (!mdl_valid) begin
    end else if (mdl_holder < 0) begin
      if (m_cyc[0] && m_cyc[1]) mdl_holder = 1 - mdl_last;
      else if (m_cyc[0])        mdl_holder = 0;
      else if (m_cyc[1])        mdl_holder = 1;
      mdl_stall = 0;
    end else if (mdl_flush) begin
      mdl_last   = mdl_holder;
      mdl_holder = -1;
      mdl_flush  = 1'b0;
    end else if (!m_cyc[mdl_holder]) begin
      mdl_last   = mdl_holder;
      mdl_holder = -1;
      mdl_stall  = 0;
    end else if (s_ack || !m_stb[mdl_holder]) begin
      mdl_stall = 0;
    end else begin
      mdl_stall++;
      if (mdl_stall >= TIMEOUT) begin
        mdl_flush = 1'b1;
        mdl_tflag = 1'b1;
        mdl_stall = 0;
      end
    end
  endtask

  task automatic compareAll();
    logic [0:31] hold_dat, other_dat;
    logic        hold_ack, other_ack;
    if (mdl_holder < 0) begin
      checkOutput("idle_busy",  busy,     0);
      checkOutput("idle_scyc",  s_cyc_o,  0);
      checkOutput("idle_sstb",  s_stb_o,  0);
      checkOutput("idle_ack0",  m0_ack_o, 0);
      checkOutput("idle_ack1",  m1_ack_o, 0);
    end else begin
      hold_ack  = (mdl_holder == 1) ? m1_ack_o : m0_ack_o;
      hold_dat  = (mdl_holder == 1) ? m1_dat_o : m0_dat_o;
      other_ack = (mdl_holder == 1) ? m0_ack_o : m1_ack_o;
      other_dat = (mdl_holder == 1) ? m0_dat_o : m1_dat_o;
      checkOutput("busy",      busy,      1);
      checkOutput("owner",     owner,     32'(mdl_holder));
      checkOutput("other_ack", other_ack, 0);
      checkOutput("other_dat", other_dat, 0);
      if (mdl_flush) begin
        checkOutput("flush_scyc", s_cyc_o,  0);
        checkOutput("flush_sstb", s_stb_o,  0);
        checkOutput("flush_ack",  hold_ack, 1);
        checkOutput("flush_dat",  hold_dat, 32'hFFFF_FFFF);
      end else begin
        checkOutput("s_cyc", s_cyc_o,  m_cyc[mdl_holder]);
        checkOutput("s_stb", s_stb_o,  m_stb[mdl_holder]);
        checkOutput("s_adr", s_adr_o,  m_adr[mdl_holder]);
        checkOutput("s_dat", s_dat_o,  m_dat[mdl_holder]);
        checkOutput("s_we",  s_we_o,   m_we[mdl_holder]);
        checkOutput("s_sel", s_sel_o,  m_sel[mdl_holder]);
        checkOutput("m_ack", hold_ack, s_ack);
        checkOutput("m_dat", hold_dat, s_dat);
      end
    end
    checkOutput("timeout_flag", timeout_flag, mdl_tflag);
  endtask

  initial begin
    forever begin
      @(posedge clk);
      updateModel();
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (mdl_valid) compareAll();
    end
  end

  initial begin
    rst = 1'b1;
    idleInputs();

    // Single read from m0, slave answers in the third cycle.
    applyReset();
    request(0, 30'h100);
    tick(); probe();
    checkOutput("t1_busy",  busy,     1);
    checkOutput("t1_owner", owner,    0);
    checkOutput("t1_scyc",  s_cyc_o,  1);
    checkOutput("t1_sadr",  s_adr_o,  30'h100);
    checkOutput("t1_ack0",  m0_ack_o, 0);
    tick();
    tick();
    s_ack = 1'b1;
    s_dat = 32'h1234_5678;
    probe();
    checkOutput("t1_ack",   m0_ack_o, 1);
    checkOutput("t1_dat",   m0_dat_o, 32'h1234_5678);
    checkOutput("t1_m1ack", m1_ack_o, 0);
    tick();
    s_ack = 1'b0;
    release_m(0);
    probe();
    checkOutput("t1_ack_once", m0_ack_o, 0);
    tick(); probe();
    checkOutput("t1_idle", busy, 0);

    // Simultaneous requests right after reset: round-robin order.
    applyReset();
    request(0, 30'h200);
    request(1, 30'h300);
    tick(); probe();
    checkOutput("t2_first_owner", owner, 0);
    release_m(0);
    tick(); probe();
    checkOutput("t2_gap_idle", busy, 0);
    tick(); probe();
    checkOutput("t2_second_owner", owner, 1);
    checkOutput("t2_second_busy",  busy,  1);
    release_m(1);
    tick();
    request(0, 30'h201);
    request(1, 30'h301);
    tick(); probe();
    checkOutput("t2_tie_owner", owner, 0);
    release_m(0);
    release_m(1);
    tick();
    tick();

    // m1 4-beat burst while m0 waits.
    request(1, 30'h400);
    tick(); probe();
    checkOutput("t3_owner", owner, 1);
    request(0, 30'h500);
    for (int b = 0; b < 4; b++) begin
      tick();
      s_ack = 1'b1;
      s_dat = 32'hBEEF_0000 + 32'(b);
      probe();
      checkOutput("t3_beat_ack1", m1_ack_o, 1);
      checkOutput("t3_beat_dat1", m1_dat_o, 32'hBEEF_0000 + 32'(b));
      checkOutput("t3_beat_ack0", m0_ack_o, 0);
      tick();
      s_ack = 1'b0;
      m_adr[1] = m_adr[1] + 30'd1;
    end
    release_m(1);
    tick(); probe();
    checkOutput("t3_release_idle", busy, 0);
    tick(); probe();
    checkOutput("t3_m0_owner", owner, 0);
    release_m(0);
    tick();
    tick();

    // Ack on the last allowed stall cycle wins, then a real timeout.
    request(0, 30'h600);
    tick();
    for (int k = 0; k < TIMEOUT - 1; k++) tick();
    s_ack = 1'b1;
    s_dat = 32'hA5A5_A5A5;
    probe();
    checkOutput("t4_late_ack", m0_ack_o, 1);
    checkOutput("t4_late_dat", m0_dat_o, 32'hA5A5_A5A5);
    tick();
    s_ack = 1'b0;
    probe();
    checkOutput("t4_no_flush_stb", s_stb_o,      1);
    checkOutput("t4_no_flag",      timeout_flag, 0);
    for (int k = 0; k < TIMEOUT - 1; k++) tick();
    probe();
    checkOutput("t4_pre_flush_ack", m0_ack_o, 0);
    checkOutput("t4_pre_flush_stb", s_stb_o,  1);
    tick(); probe();
    checkOutput("t4_flush_ack",  m0_ack_o,     1);
    checkOutput("t4_flush_dat",  m0_dat_o,     32'hFFFF_FFFF);
    checkOutput("t4_flush_stb",  s_stb_o,      0);
    checkOutput("t4_flush_flag", timeout_flag, 1);
    release_m(0);
    tick(); probe();
    checkOutput("t4_after_idle", busy, 0);
    tick(); tick(); tick(); probe();
    checkOutput("t4_flag_sticky", timeout_flag, 1);

    // Reset while m1 has a strobe outstanding.
    request(1, 30'h700);
    tick(); probe();
    checkOutput("t5_owner", owner,   1);
    checkOutput("t5_stb",   s_stb_o, 1);
    rst   = 1'b1;
    s_ack = 1'b1;
    tick(); probe();
    checkOutput("t5_scyc", s_cyc_o,      0);
    checkOutput("t5_busy", busy,         0);
    checkOutput("t5_flag", timeout_flag, 0);
    checkOutput("t5_ack1", m1_ack_o,     0);
    rst   = 1'b0;
    s_ack = 1'b0;
    request(0, 30'h800);
    tick(); probe();
    checkOutput("t5_tie_owner", owner, 0);
    idleInputs();
    tick();
    tick();

    // Randomized traffic, alternating normal and stall-heavy phases.
    for (int c = 0; c < 4000; c++) begin
      tick();
      applyStimulus((c / 250) % 2);
    end

    rst = 1'b0;
    idleInputs();
    tick();
    tick();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
